// File: rtl/pool_window_if.sv
// Handshake bundle between the pool window sequencer, its upstream pixel
// source and the next layer.
interface pool_window_if #(
  parameter int IDX_W = 1
) ();
  logic             i_start;
  logic             i_pixel_we;
  logic             o_ready;
  logic             i_next_ready;
  logic             o_next_we;
  logic             o_next_start;
  logic [IDX_W-1:0] o_out_idx;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_start,
    output i_pixel_we,
    output i_next_ready,
    input  o_ready,
    input  o_next_we,
    input  o_next_start,
    input  o_out_idx,
    input  o_busy,
    input  o_err
  );

  modport slave (
    input  i_start,
    input  i_pixel_we,
    input  i_next_ready,
    output o_ready,
    output o_next_we,
    output o_next_start,
    output o_out_idx,
    output o_busy,
    output o_err
  );
endinterface

// File: rtl/pool_window_ctrl.sv
// Frame sequencer for the max-pool datapath: raster tracking, stride-aligned
// window detection and next-layer write gating. Optional POOL_WINDOW_CTRL_ERR_EN adds a sticky protocol error flag.
module pool_window_ctrl #(
  parameter int IMG_DIM    = 13,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 2
) (
  input  logic          clk,
  input  logic          rst,
  pool_window_if.slave  bus
);
  localparam int OUT_DIM = (IMG_DIM - KERNEL_DIM) / STRIDE + 1;
  localparam int OUT_CNT = OUT_DIM * OUT_DIM;
  localparam int CW      = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int SW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int IDX_W   = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1;

  localparam logic [CW-1:0]    LAST_POS     = CW'(IMG_DIM - 1);
  localparam logic [CW-1:0]    FIRST_WIN    = CW'(KERNEL_DIM - 1);
  localparam logic [SW-1:0]    PHASE_RELOAD = SW'(STRIDE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(OUT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    col_r;
  logic [CW-1:0]    col_s;
  logic [CW-1:0]    row_r;
  logic [CW-1:0]    row_s;
  logic [SW-1:0]    col_phase_r;
  logic [SW-1:0]    col_phase_s;
  logic [SW-1:0]    row_phase_r;
  logic [SW-1:0]    row_phase_s;
  logic [IDX_W-1:0] out_idx_r;
  logic [IDX_W-1:0] out_idx_s;
  logic             next_we_r;
  logic             next_start_r;
  logic             busy_r;

  logic ready_s;
  logic accept_s;
  logic col_wrap_s;
  logic last_pix_s;
  logic frame_go_s;
  logic win_s;

  // Handshake qualification and window decision for the pixel on the bus now
  always_comb begin
    ready_s    = (state_r == ST_STREAM) && bus.i_next_ready;
    accept_s   = ready_s && bus.i_pixel_we;
    col_wrap_s = (col_r == LAST_POS);
    last_pix_s = col_wrap_s && (row_r == LAST_POS);
    frame_go_s = (state_r == ST_IDLE) && bus.i_start;
    win_s      = accept_s
                 && (row_r >= FIRST_WIN) && (col_r >= FIRST_WIN)
                 && (row_phase_r == {SW{1'b0}}) && (col_phase_r == {SW{1'b0}});
  end

  // Frame state transitions
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_pix_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Raster and stride-phase counters. A phase of zero marks a stride-aligned
  // position; the column phase is re-armed to zero at every row wrap.
  always_comb begin
    col_s       = col_r;
    row_s       = row_r;
    col_phase_s = col_phase_r;
    row_phase_s = row_phase_r;
    if (frame_go_s) begin
      col_s       = {CW{1'b0}};
      row_s       = {CW{1'b0}};
      col_phase_s = {SW{1'b0}};
      row_phase_s = {SW{1'b0}};
    end else if (accept_s) begin
      if (col_wrap_s) begin
        col_s       = {CW{1'b0}};
        col_phase_s = {SW{1'b0}};
        if (last_pix_s) begin
          row_s = {CW{1'b0}};
        end else begin
          row_s = row_r + CW'(1);
        end
        if (row_r >= FIRST_WIN) begin
          if (row_phase_r == {SW{1'b0}}) begin
            row_phase_s = PHASE_RELOAD;
          end else begin
            row_phase_s = row_phase_r - SW'(1);
          end
        end else begin
          row_phase_s = row_phase_r;
        end
      end else begin
        col_s = col_r + CW'(1);
        if (col_r >= FIRST_WIN) begin
          if (col_phase_r == {SW{1'b0}}) begin
            col_phase_s = PHASE_RELOAD;
          end else begin
            col_phase_s = col_phase_r - SW'(1);
          end
        end else begin
          col_phase_s = col_phase_r;
        end
      end
    end else begin
      col_s       = col_r;
      row_s       = row_r;
      col_phase_s = col_phase_r;
      row_phase_s = row_phase_r;
    end
  end

  // Output index advances once each pooled pixel has been presented
  always_comb begin
    out_idx_s = out_idx_r;
    if (frame_go_s) begin
      out_idx_s = {IDX_W{1'b0}};
    end else if (next_we_r) begin
      if (out_idx_r == LAST_IDX) begin
        out_idx_s = {IDX_W{1'b0}};
      end else begin
        out_idx_s = out_idx_r + IDX_W'(1);
      end
    end else begin
      out_idx_s = out_idx_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      col_r        <= {CW{1'b0}};
      row_r        <= {CW{1'b0}};
      col_phase_r  <= {SW{1'b0}};
      row_phase_r  <= {SW{1'b0}};
      out_idx_r    <= {IDX_W{1'b0}};
      next_we_r    <= 1'b0;
      next_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      col_r        <= col_s;
      row_r        <= row_s;
      col_phase_r  <= col_phase_s;
      row_phase_r  <= row_phase_s;
      out_idx_r    <= out_idx_s;
      next_we_r    <= win_s;
      next_start_r <= (state_r == ST_DONE);
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign bus.o_ready      = ready_s;
  assign bus.o_next_we    = next_we_r;
  assign bus.o_next_start = next_start_r;
  assign bus.o_out_idx    = out_idx_r;
  assign bus.o_busy       = busy_r;

`ifdef POOL_WINDOW_CTRL_ERR_EN
  logic err_r;
  logic err_hit_s;

  // Protocol violations seen from upstream
  always_comb begin
    err_hit_s = (bus.i_pixel_we && !ready_s)
                || (bus.i_start && busy_r)
                || (bus.i_pixel_we && (state_r == ST_IDLE));
  end

  // Sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (err_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.o_err = err_r;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule
